// File: rtl/uart_ovs_pkg.sv
// Shared constants, state encodings and helpers for the oversampling UART core.
// Optional parity support is selected with the UART_OVS_PARITY_EN macro.
package uart_ovs_pkg;

   localparam int unsigned Oversample = 16;
   localparam int unsigned MidTick    = 7;
   localparam int unsigned LastTick   = Oversample - 1;

   typedef enum logic [2:0] {
      TxIdle,
      TxStart,
      TxData,
`ifdef UART_OVS_PARITY_EN
      TxParity,
`endif
      TxStop
   } tx_state_e;

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
`ifdef UART_OVS_PARITY_EN
      RxParity,
`endif
      RxStop
   } rx_state_e;

   // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
   function automatic logic par_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_ovs_tick.sv
// Free-running oversample tick generator shared by the TX and RX paths.
// A tick is issued once the count reaches baud_div, so shrinking the divider never strands it.
module uart_ovs_tick
   import uart_ovs_pkg::*;
#(
   parameter int unsigned P_DIV_W = 16
) (
   input  logic               iUART_CLOCK,
   input  logic               inRESET,
   input  logic [P_DIV_W-1:0] baud_div,
   output logic               tick
);

   logic [P_DIV_W-1:0] cnt_q;

   assign tick = (cnt_q >= baud_div);

   // Count clocks; clear on every tick.
   always_ff @(posedge iUART_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + P_DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_ovs_core.sv
// 16x oversampling UART: TX and RX with valid/ready handshakes, frame error and sticky overrun.
// Define UART_OVS_PARITY_EN to insert a parity bit in both directions.
module uart_ovs_core
   import uart_ovs_pkg::*;
#(
   parameter int unsigned P_DATA_W    = 8,
   parameter int unsigned P_DIV_W     = 16,
   parameter bit          P_MSB_FIRST = 1'b0
) (
   input  logic                iUART_CLOCK,
   input  logic                inRESET,
   input  logic [P_DIV_W-1:0]  iBAUD_DIV,
   input  logic                iTX_EN,
   input  logic                iTX_VALID,
   output logic                oTX_READY,
   input  logic [P_DATA_W-1:0] iTX_DATA,
   input  logic                iRX_EN,
   output logic                oRX_VALID,
   input  logic                iRX_READY,
   output logic [P_DATA_W-1:0] oRX_DATA,
   output logic                oRX_FRAME_ERR,
   output logic                oRX_OVERRUN,
   input  logic                iERR_CLR,
`ifdef UART_OVS_PARITY_EN
   input  logic                iPARITY_ODD,
   output logic                oRX_PARITY_ERR,
`endif
   output logic                oUART_TXD,
   input  logic                iUART_RXD
);

   localparam logic [2:0] LastBit = 3'(P_DATA_W - 1);

   logic tick;

   uart_ovs_tick #(.P_DIV_W(P_DIV_W)) u_tick (
      .iUART_CLOCK(iUART_CLOCK),
      .inRESET    (inRESET),
      .baud_div   (iBAUD_DIV),
      .tick       (tick)
   );

   // ---------------------------------------------------------------- TX
   tx_state_e           tx_state_q, tx_state_d;
   logic [3:0]          tx_cnt_q, tx_cnt_d;
   logic [2:0]          tx_bits_q, tx_bits_d;
   logic [P_DATA_W-1:0] tx_sh_q, tx_sh_d, tx_load;
   logic                txd_q, txd_d;
`ifdef UART_OVS_PARITY_EN
   logic                tx_par_q, tx_par_d;
`endif

   // Ready is masked by reset so it reads 0 while the core is held.
   assign oTX_READY = (tx_state_q == TxIdle) && iTX_EN && inRESET;
   assign oUART_TXD = txd_q;

   // Shift register always shifts out bit 0, so MSB-first data is loaded reversed.
   always_comb begin
      tx_load = '0;
      for (int i = 0; i < P_DATA_W; i++) begin
         tx_load[i] = P_MSB_FIRST ? iTX_DATA[P_DATA_W-1-i] : iTX_DATA[i];
      end
   end

   // TX next state: each non-idle state lasts 16 ticks; txd is registered from the next state.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bits_d  = tx_bits_q;
      tx_sh_d    = tx_sh_q;
      txd_d      = txd_q;
`ifdef UART_OVS_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         TxIdle: begin
            txd_d = 1'b1;
            if (oTX_READY && iTX_VALID) begin
               tx_state_d = TxStart;
               tx_cnt_d   = '0;
               tx_sh_d    = tx_load;
               txd_d      = 1'b0;
`ifdef UART_OVS_PARITY_EN
               tx_par_d   = par_bit(8'(iTX_DATA), iPARITY_ODD);
`endif
            end
         end
         default: begin
            if (tick) begin
               tx_cnt_d = tx_cnt_q + 4'd1;
               if (tx_cnt_q == 4'(LastTick)) begin
                  case (tx_state_q)
                     TxStart: begin
                        tx_state_d = TxData;
                        tx_bits_d  = '0;
                        txd_d      = tx_sh_q[0];
                     end
                     TxData: begin
                        if (tx_bits_q == LastBit) begin
`ifdef UART_OVS_PARITY_EN
                           tx_state_d = TxParity;
                           txd_d      = tx_par_q;
`else
                           tx_state_d = TxStop;
                           txd_d      = 1'b1;
`endif
                        end else begin
                           tx_bits_d = tx_bits_q + 3'd1;
                           tx_sh_d   = tx_sh_q >> 1;
                           txd_d     = tx_sh_q[1];
                        end
                     end
`ifdef UART_OVS_PARITY_EN
                     TxParity: begin
                        tx_state_d = TxStop;
                        txd_d      = 1'b1;
                     end
`endif
                     default: begin
                        tx_state_d = TxIdle;
                        txd_d      = 1'b1;
                     end
                  endcase
               end
            end
         end
      endcase
   end

   // TX state register.
   always_ff @(posedge iUART_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bits_q  <= '0;
         tx_sh_q    <= '0;
         txd_q      <= 1'b1;
`ifdef UART_OVS_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bits_q  <= tx_bits_d;
         tx_sh_q    <= tx_sh_d;
         txd_q      <= txd_d;
`ifdef UART_OVS_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   // ---------------------------------------------------------------- RX
   logic [1:0]          sync_q;
   logic                rxd_s;
   rx_state_e           rx_state_q, rx_state_d;
   logic [3:0]          rx_cnt_q, rx_cnt_d;
   logic [2:0]          rx_bits_q, rx_bits_d;
   logic [P_DATA_W-1:0] rx_sh_q, rx_sh_d, rx_shift;
   logic                deliver, stop_bad, pop, drop;
`ifdef UART_OVS_PARITY_EN
   logic                rx_perr_q, rx_perr_d, perr_q;
   assign oRX_PARITY_ERR = perr_q;
`endif

   assign rxd_s    = sync_q[1];
   assign rx_shift = P_MSB_FIRST ? {rx_sh_q[P_DATA_W-2:0], rxd_s}
                                 : {rxd_s, rx_sh_q[P_DATA_W-1:1]};
   assign pop      = oRX_VALID && iRX_READY;
   assign drop     = deliver && oRX_VALID && !iRX_READY;

   // Two-flop synchroniser on the asynchronous serial input; idles high.
   always_ff @(posedge iUART_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], iUART_RXD};
      end
   end

   // RX next state: sample at tick 7 of each window, advance at tick 15, deliver at stop sample.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bits_d  = rx_bits_q;
      rx_sh_d    = rx_sh_q;
      deliver    = 1'b0;
      stop_bad   = 1'b0;
`ifdef UART_OVS_PARITY_EN
      rx_perr_d  = rx_perr_q;
`endif
      case (rx_state_q)
         RxIdle: begin
            if (iRX_EN && !rxd_s) begin
               rx_state_d = RxStart;
               rx_cnt_d   = '0;
            end
         end
         default: begin
            if (tick) begin
               rx_cnt_d = rx_cnt_q + 4'd1;
               if (rx_cnt_q == 4'(MidTick)) begin
                  case (rx_state_q)
                     RxStart: if (rxd_s) rx_state_d = RxIdle;
                     RxData:  rx_sh_d = rx_shift;
`ifdef UART_OVS_PARITY_EN
                     RxParity: rx_perr_d = rxd_s ^ par_bit(8'(rx_sh_q), iPARITY_ODD);
`endif
                     default: begin
                        deliver    = 1'b1;
                        stop_bad   = !rxd_s;
                        rx_state_d = RxIdle;
                     end
                  endcase
               end else if (rx_cnt_q == 4'(LastTick)) begin
                  case (rx_state_q)
                     RxStart: begin
                        rx_state_d = RxData;
                        rx_bits_d  = '0;
                     end
                     RxData: begin
                        if (rx_bits_q == LastBit) begin
`ifdef UART_OVS_PARITY_EN
                           rx_state_d = RxParity;
`else
                           rx_state_d = RxStop;
`endif
                        end else begin
                           rx_bits_d = rx_bits_q + 3'd1;
                        end
                     end
                     default: rx_state_d = RxStop;
                  endcase
               end
            end
         end
      endcase
   end

   // RX state register.
   always_ff @(posedge iUART_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bits_q  <= '0;
         rx_sh_q    <= '0;
`ifdef UART_OVS_PARITY_EN
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bits_q  <= rx_bits_d;
         rx_sh_q    <= rx_sh_d;
`ifdef UART_OVS_PARITY_EN
         rx_perr_q  <= rx_perr_d;
`endif
      end
   end

   // Output holding register: an unpopped frame is kept and a new one is dropped as overrun.
   always_ff @(posedge iUART_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         oRX_VALID     <= 1'b0;
         oRX_DATA      <= '0;
         oRX_FRAME_ERR <= 1'b0;
         oRX_OVERRUN   <= 1'b0;
`ifdef UART_OVS_PARITY_EN
         perr_q        <= 1'b0;
`endif
      end else begin
         if (deliver && !drop) begin
            oRX_VALID     <= 1'b1;
            oRX_DATA      <= rx_sh_q;
            oRX_FRAME_ERR <= stop_bad;
`ifdef UART_OVS_PARITY_EN
            perr_q        <= rx_perr_q;
`endif
         end else if (pop) begin
            oRX_VALID <= 1'b0;
         end
         if (drop) begin
            oRX_OVERRUN <= 1'b1;
         end else if (iERR_CLR) begin
            oRX_OVERRUN <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_ovs_core.sv
// Self-checking bench for uart_ovs_core (default parameters; honours UART_OVS_PARITY_EN).
module tb_uart_ovs_core;

`ifdef UART_OVS_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } rx_item_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] baud_div;
   logic        tx_en, tx_valid, tx_ready;
   logic [7:0]  tx_data;
   logic        rx_en, rx_valid, rx_ready;
   logic [7:0]  rx_data;
   logic        rx_ferr, rx_ovr, err_clr;
   logic        txd, rxd_line, rxd_drv, loop_en;
`ifdef UART_OVS_PARITY_EN
   logic        par_odd, rx_perr, par_flip;
`endif

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          tx_t0 = 0;
   int          tx_n;
   logic        tx_chk = 1'b0;
   logic [FL-1:0] tx_frame;
   rx_item_t    exp_q[$];

   assign rxd_line = loop_en ? txd : rxd_drv;

   uart_ovs_core dut (
      .iUART_CLOCK   (clk),
      .inRESET       (rst_n),
      .iBAUD_DIV     (baud_div),
      .iTX_EN        (tx_en),
      .iTX_VALID     (tx_valid),
      .oTX_READY     (tx_ready),
      .iTX_DATA      (tx_data),
      .iRX_EN        (rx_en),
      .oRX_VALID     (rx_valid),
      .iRX_READY     (rx_ready),
      .oRX_DATA      (rx_data),
      .oRX_FRAME_ERR (rx_ferr),
      .oRX_OVERRUN   (rx_ovr),
      .iERR_CLR      (err_clr),
`ifdef UART_OVS_PARITY_EN
      .iPARITY_ODD   (par_odd),
      .oRX_PARITY_ERR(rx_perr),
`endif
      .oUART_TXD     (txd),
      .iUART_RXD     (rxd_line)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Line image of a frame: index 0 is the start bit, then data LSB first, [parity], stop.
   function automatic logic [FL-1:0] frame_of(input logic [7:0] d);
      logic [FL-1:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef UART_OVS_PARITY_EN
      f[9]   = (^d) ^ par_odd;
`endif
      return f;
   endfunction

   // Compare process: TX line and ready against the frame model; RX pops against the queue.
   always @(negedge clk) begin
      if (tx_chk) begin
         tx_n = cyc - tx_t0;
         if (tx_n >= 0 && tx_n < FL * 16 + 8) begin
            check("txd_line", txd, (tx_n < FL * 16) ? tx_frame[tx_n / 16] : 1'b1);
            check("tx_ready_timing", tx_ready, tx_n >= FL * 16);
         end
      end
      if (rst_n && rx_valid && rx_ready) begin
         check("rx_pop_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            check("rx_data", rx_data, exp_q[0].data);
            check("rx_frame_err", rx_ferr, exp_q[0].ferr);
`ifdef UART_OVS_PARITY_EN
            check("rx_parity_err", rx_perr, exp_q[0].perr);
`endif
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait for ready, then hand over one byte; tx_t0 marks the cycle after the handshake edge.
   task automatic send_byte(input logic [7:0] d);
      int k = 0;
      while (!tx_ready && k < 3000) begin
         step(1);
         k++;
      end
      check("tx_ready_wait", k < 3000, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      step(1);
      tx_valid = 1'b0;
      tx_t0    = cyc;
   endtask

   task automatic rx_bit(input logic b);
      rxd_drv = b;
      step(16);
   endtask

   // Bit-banged frame at iBAUD_DIV = 0 (16 clocks per bit), followed by one idle bit time.
   task automatic rx_frame(input logic [7:0] d, input logic stop);
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(d[i]);
`ifdef UART_OVS_PARITY_EN
      rx_bit((^d) ^ par_odd ^ par_flip);
`endif
      rx_bit(stop);
      rx_bit(1'b1);
   endtask

   task automatic drain(input int lim);
      int k = 0;
      while (exp_q.size() != 0 && k < lim) begin
         step(1);
         k++;
      end
      check("rx_drain", exp_q.size(), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      baud_div = 16'd0;
      tx_en    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rx_en    = 1'b1;
      rx_ready = 1'b1;
      err_clr  = 1'b0;
      rxd_drv  = 1'b1;
      loop_en  = 1'b0;
`ifdef UART_OVS_PARITY_EN
      par_odd  = 1'b0;
      par_flip = 1'b0;
`endif
      step(3);
      check("rst_txd", txd, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_frame_err", rx_ferr, 0);
      check("rst_overrun", rx_ovr, 0);
`ifdef UART_OVS_PARITY_EN
      check("rst_parity_err", rx_perr, 0);
`endif
      rst_n = 1'b1;
      step(3);

      // 0xA5 at full rate: cycle-by-cycle line check plus literal pins.
`ifndef UART_OVS_PARITY_EN
      check("model_frame_a5", frame_of(8'hA5), 10'b1101001010);
`endif
      tx_frame = frame_of(8'hA5);
      send_byte(8'hA5);
      tx_chk = 1'b1;
      check("a5_start_bit", txd, 0);
      step(16);
      check("a5_bit0", txd, 1);
      step(16);
      check("a5_bit1", txd, 0);
`ifndef UART_OVS_PARITY_EN
      step(127);
      check("a5_ready_159", tx_ready, 0);
      step(1);
      check("a5_ready_160", tx_ready, 1);
`endif
      step(40);
      tx_chk = 1'b0;

      // Reset in the middle of a frame aborts it at once.
      send_byte(8'h5A);
      step(40);
      rst_n = 1'b0;
      #1;
      check("midreset_txd", txd, 1);
      check("midreset_ready", tx_ready, 0);
      step(2);
      rst_n = 1'b1;
      step(2);

      // Loopback at iBAUD_DIV = 3, three back-to-back frames.
      baud_div = 16'd3;
      loop_en  = 1'b1;
      exp_q.push_back('{8'h3C, 1'b0, 1'b0});
      exp_q.push_back('{8'hFF, 1'b0, 1'b0});
      exp_q.push_back('{8'h00, 1'b0, 1'b0});
      send_byte(8'h3C);
      send_byte(8'hFF);
      send_byte(8'h00);
      drain(3000);
      send_byte(8'h00);
      exp_q.push_back('{8'h00, 1'b0, 1'b0});
      drain(3000);
      check("loop_overrun", rx_ovr, 0);
      step(700);
      loop_en  = 1'b0;
      baud_div = 16'd0;
      step(20);

      // False start, then a good 0x55.
      rxd_drv = 1'b0;
      step(4);
      rxd_drv = 1'b1;
      step(40);
      check("false_start_valid", rx_valid, 0);
      exp_q.push_back('{8'h55, 1'b0, 1'b0});
      rx_frame(8'h55, 1'b1);
      drain(100);

      // Stop bit low: data kept, frame error flagged.
      exp_q.push_back('{8'h81, 1'b1, 1'b0});
      rx_frame(8'h81, 1'b0);
      drain(100);
      step(20);

      // Overrun: consumer stalled across two frames.
      rx_ready = 1'b0;
      rx_frame(8'h11, 1'b1);
      check("ovr_first_valid", rx_valid, 1);
      check("ovr_first_data", rx_data, 8'h11);
      check("ovr_not_yet", rx_ovr, 0);
      rx_frame(8'h22, 1'b1);
      check("ovr_set", rx_ovr, 1);
      check("ovr_data_kept", rx_data, 8'h11);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("ovr_cleared", rx_ovr, 0);
      exp_q.push_back('{8'h11, 1'b0, 1'b0});
      rx_ready = 1'b1;
      step(1);
      check("ovr_pop_valid", rx_valid, 0);
      drain(10);

`ifdef UART_OVS_PARITY_EN
      // Even parity of 0x07 is 1; a flipped parity bit on the line is reported.
      tx_frame = frame_of(8'h07);
      send_byte(8'h07);
      tx_chk = 1'b1;
      step(144);
      check("par_tx_bit", txd, 1);
      step(40);
      tx_chk = 1'b0;
      par_flip = 1'b1;
      exp_q.push_back('{8'h07, 1'b0, 1'b1});
      rx_frame(8'h07, 1'b1);
      drain(100);
      par_flip = 1'b0;
`endif

      step(10);
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
